// File: rtl/itag_pkg.sv
// rtl/itag_pkg.sv - shared widths, FSM encoding and way-count helper for the I-cache tag array
`ifndef I_TAG_WIDTH
`define I_TAG_WIDTH 12
`endif
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 7
`endif

package itag_pkg;
  localparam int TAG_W_DEF = `I_TAG_WIDTH;
  localparam int IDX_W_DEF = `I_INDEX_WIDTH;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic int way_bits(input int ways);
    int b;
    b = 0;
    while ((1 << b) < ways) b++;
    return (b < 1) ? 1 : b;
  endfunction
endpackage

// File: rtl/itag_way.sv
// rtl/itag_way.sv - one way of tag/valid storage with registered tag compare
// Optional parity storage and checking with ITAG_PARITY_EN.
module itag_way
  import itag_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inv,
  input  logic [IDX_W-1:0] inv_index,
  input  logic             we,
  input  logic [IDX_W-1:0] w_index,
  input  logic [TAG_W-1:0] w_tag,
  input  logic             lk_en,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  output logic             vld,
  output logic             perr
);
  localparam int SETS = 1 << IDX_W;

  logic [TAG_W-1:0] tag_mem [SETS];
  logic [SETS-1:0]  valid;

`ifdef ITAG_PARITY_EN
  logic [SETS-1:0]  par;
  logic [IDX_W-1:0] lk_idx_q;
  logic             bad;

  assign bad = valid[lk_index] & ((^tag_mem[lk_index]) ^ par[lk_index]);

  // Tag contents need no reset; valid bits are cleared by the sweep.
  always_ff @(posedge clk) begin
    if (perr) valid[lk_idx_q] <= 1'b0;
    if (inv) valid[inv_index] <= 1'b0;
    if (we) begin
      tag_mem[w_index] <= w_tag;
      par[w_index]     <= ^w_tag;
      valid[w_index]   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit      <= 1'b0;
      vld      <= 1'b0;
      perr     <= 1'b0;
      lk_idx_q <= '0;
    end else begin
      perr <= 1'b0;
      if (lk_en) begin
        vld      <= valid[lk_index];
        hit      <= valid[lk_index] && (tag_mem[lk_index] == lk_tag) && !bad;
        perr     <= bad;
        lk_idx_q <= lk_index;
      end
    end
  end
`else
  assign perr = 1'b0;

  always_ff @(posedge clk) begin
    if (inv) valid[inv_index] <= 1'b0;
    if (we) begin
      tag_mem[w_index] <= w_tag;
      valid[w_index]   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit <= 1'b0;
      vld <= 1'b0;
    end else if (lk_en) begin
      vld <= valid[lk_index];
      hit <= valid[lk_index] && (tag_mem[lk_index] == lk_tag);
    end
  end
`endif
endmodule

// File: rtl/itag_array.sv
// rtl/itag_array.sv - N-way I-cache tag array with sweep FSM and round-robin victim selection
// Parity checking is built when ITAG_PARITY_EN is defined.
module itag_array
  import itag_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int TAG_W = TAG_W_DEF,
  parameter  int IDX_W = IDX_W_DEF,
  localparam int WAY_W = way_bits(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             busy,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             rsp_valid,
  output logic             hit,
  output logic [WAYS-1:0]  hit_way,
  output logic [WAY_W-1:0] victim_way,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             inv_valid,
  input  logic [IDX_W-1:0] inv_index,
  input  logic             flush_req,
  output logic             parity_err
);
  localparam int SETS = 1 << IDX_W;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [WAY_W-1:0] rr [SETS];
  logic [WAY_W-1:0] rr_q;
  logic [WAYS-1:0]  vld_q;
  logic [WAYS-1:0]  perr_w;
  logic             sweep, lk_acc, fill_acc, inv_acc, way_inv;
  logic [IDX_W-1:0] way_inv_index;

  // Flush wins over fill, fill wins over inv; the lookup is independent.
  assign sweep         = (state != ST_IDLE);
  assign lk_acc        = lk_valid & ~busy;
  assign fill_acc      = ~sweep & fill_valid & ~flush_req;
  assign inv_acc       = ~sweep & inv_valid & ~fill_valid & ~flush_req;
  assign way_inv       = sweep | inv_acc;
  assign way_inv_index = sweep ? cnt : inv_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rr_q      <= '0;
    end else begin
      rsp_valid <= lk_acc;
      if (lk_acc) rr_q <= rr[lk_index];
      case (state)
        ST_INIT, ST_FLUSH: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(SETS - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (flush_req) begin
            state <= ST_FLUSH;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sweep) rr[cnt] <= '0;
    else if (fill_acc) rr[fill_index] <= fill_way + 1'b1;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    itag_way #(.TAG_W(TAG_W), .IDX_W(IDX_W)) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .inv       (way_inv),
      .inv_index (way_inv_index),
      .we        (fill_acc && (fill_way == WAY_W'(w))),
      .w_index   (fill_index),
      .w_tag     (fill_tag),
      .lk_en     (lk_acc),
      .lk_index  (lk_index),
      .lk_tag    (lk_tag),
      .hit       (hit_way[w]),
      .vld       (vld_q[w]),
      .perr      (perr_w[w])
    );
  end

  assign hit        = |hit_way;
  assign parity_err = |perr_w;

  // Lowest-index invalid way first, otherwise the set's round-robin pointer.
  always_comb begin
    victim_way = rr_q;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld_q[w]) victim_way = WAY_W'(w);
    end
  end
endmodule
